joy_db15_tx: RTL
================

// Module: joy_db15_tx
// PURPOSE
//  Device-side emulator of the DB15 serial joystick adapter: the shift-register end of the
//  JOY_LOAD/JOY_CLK/JOY_DATA link that joy_db15 polls. Snapshots two 12-button pad words on
//  load, then shifts them out MSB-first on each host clock rising edge, as a 74HC165 chain.
//  Used by loopback benches, and to present OSD/USB pad state on the UserIO port to a host.
// PARAMETERS
//  PLAYER_BITS  12  buttons per player; frame length = 2*PLAYER_BITS
//  SYNC_STAGES  2   synchroniser flops on joy_clk/joy_load (>=2)
// PORTS
//  clk          in   1   system clock (40-50 MHz, same domain as CLK_JOY)
//  reset_n      in   1   asynchronous reset, active low
//  joystick1    in   12  player 1 buttons, active high (bit0=R,1=L,2=D,3=U,4..11=A,B,C,X,Y,Z,S,M)
//  joystick2    in   12  player 2 buttons, same layout
//  joy_load     in   1   host parallel-load strobe, active low, async to clk
//  joy_clk      in   1   host shift clock, async to clk; shift on rising edge
//  joy_data     out  1   serial data, active low on the wire (0 = pressed)
//  frame_done   out  1   1-cycle pulse when last frame bit has been consumed
//  busy         out  1   high from load release until frame_done or next load
// BEHAVIOUR
//  Reset: joy_data=1, frame_done=0, busy=0, bit_cnt=0, shift reg all 1s, sync flops to idle (1).
//  Sync: joy_clk, joy_load pass SYNC_STAGES flops; edges detected on last two stages.
//  Frame word F[23:0] = {~joystick2, ~joystick1}; F[23] is first bit out (P2 Mode).
//  FSM states:
//   IDLE  : joy_data=1. load_s==0 -> LOAD.
//   LOAD  : every cycle sr <= F (live, transparent like 165 SH/LD low); joy_data=sr[23] of
//           the new value on next cycle; bit_cnt=0. load_s rising -> SHIFT, busy=1.
//   SHIFT : on clk_s rising edge: sr <= {sr[22:0],1'b1}, bit_cnt++, joy_data=new sr[23].
//           When the edge consumes bit index 23 (bit_cnt 23->24): frame_done=1 one cycle,
//           busy=0 -> DRAIN.
//   DRAIN : further clk edges shift 1s (serial-in tied high); joy_data stays 1; bit_cnt
//           saturates at 24.
//   From SHIFT or DRAIN, load_s==0 -> LOAD (abandons partial frame; no frame_done).
//  Latency: joy_data changes SYNC_STAGES+1 clk cycles after the pin-level joy_clk edge;
//   host must allow >= (SYNC_STAGES+2) clk periods between JOY_CLK edges.
//  Simultaneous: load_s low and clk_s rising in same cycle -> load wins, no shift, no count.
//  clk_s edges while in LOAD are ignored (165 behaviour). Input changes during SHIFT do not
//   affect the in-flight frame; they are captured on the next load.
//  Reset asserted mid-frame: immediate return to reset values; next frame needs a new load.
//  Widths: bit_cnt is $clog2(2*PLAYER_BITS+1) bits, saturating; no wrap.
// STRUCTURE
//  Shared pkg joy_pkg: PLAYER_BITS default, button bit index localparams, fsm enum
//   {IDLE,LOAD,SHIFT,DRAIN}, shared with joy_db15/joy_db9md benches.
//  One sub-module: joy_sync (SYNC_STAGES flop chain + rise/fall detect), instanced per input.
//  Top holds FSM, shift register, counter, output regs; all outputs registered.
// TESTING
//  1 Reset then idle, no strobes -> joy_data=1, busy=0, frame_done=0 for 1000 cycles.
//  2 joystick1=12'h001, joystick2=0, load pulse, 24 JOY_CLK edges -> bits 23..0 on joy_data
//    = 1 x23 then 0 (bit0=R pressed), exactly one frame_done after 24th edge.
//  3 Loopback with joy_db15 host, joystick1=12'hA5C, joystick2=12'h3F0 -> host joystick1/2
//    outputs match within 2 poll periods.
//  4 Load after 10 edges of a frame -> no frame_done; next full frame reads fresh data.
//  5 30 JOY_CLK edges after load -> edges 25..30 read 1, bit_cnt stays 24, single frame_done.
//  6 Change joystick1 12'h000->12'hFFF during SHIFT at bit 5 -> current frame keeps 0s,
//    following frame shows all pressed; reset_n low at bit 12 -> joy_data=1 within 1 cycle.

Source files
------------

// File: rtl/joy_pkg.sv
// Shared definitions for the DB15 joystick link: button layout, default width, link FSM states.
package joy_pkg;

  localparam int unsigned PLAYER_BITS_DEF = 12;

  localparam int unsigned BTN_R = 0;
  localparam int unsigned BTN_L = 1;
  localparam int unsigned BTN_D = 2;
  localparam int unsigned BTN_U = 3;
  localparam int unsigned BTN_A = 4;
  localparam int unsigned BTN_B = 5;
  localparam int unsigned BTN_C = 6;
  localparam int unsigned BTN_X = 7;
  localparam int unsigned BTN_Y = 8;
  localparam int unsigned BTN_Z = 9;
  localparam int unsigned BTN_S = 10;
  localparam int unsigned BTN_M = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DRAIN = 2'd3
  } joy_state_e;

endpackage

// File: rtl/joy_sync.sv
// Synchroniser for one asynchronous host line, idle-high, with rising-edge detect.
module joy_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  // One flop beyond the synchroniser chain so the edge is seen on settled stages.
  logic [STAGES:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '1;
    else          sync_q <= {sync_q[STAGES-1:0], d_i};
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~sync_q[STAGES];

endmodule

// File: rtl/joy_db15_tx.sv
// Device side of the DB15 serial pad link: behaves like a 74HC165 chain loaded with two pad words.
module joy_db15_tx
  import joy_pkg::*;
#(
  parameter int unsigned PLAYER_BITS = PLAYER_BITS_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PLAYER_BITS-1:0] joystick1,
  input  logic [PLAYER_BITS-1:0] joystick2,
  input  logic                   joy_load,
  input  logic                   joy_clk,
  output logic                   joy_data,
  output logic                   frame_done,
  output logic                   busy
);

  localparam int unsigned FRAME = 2 * PLAYER_BITS;
  localparam int unsigned CW    = $clog2(FRAME + 1);

  logic             load_s;
  logic             load_rise_unused;
  logic             clk_level_unused;
  logic             clk_rise;
  logic [FRAME-1:0] frame_w;

  joy_state_e       state_q;
  logic [FRAME-1:0] sr_q;
  logic [CW-1:0]    bit_cnt_q;
  logic             joy_data_q;
  logic             frame_done_q;
  logic             busy_q;

  joy_sync #(.STAGES(SYNC_STAGES)) u_sync_load (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (joy_load),
    .level_o (load_s),
    .rise_o  (load_rise_unused)
  );

  joy_sync #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (joy_clk),
    .level_o (clk_level_unused),
    .rise_o  (clk_rise)
  );

  // Wire polarity is active low; player 2 Mode leaves first.
  assign frame_w = {~joystick2, ~joystick1};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      sr_q         <= '1;
      bit_cnt_q    <= '0;
      joy_data_q   <= 1'b1;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      // Load low overrides everything, including a coincident shift edge.
      if (!load_s) begin
        state_q    <= LOAD;
        sr_q       <= frame_w;
        joy_data_q <= frame_w[FRAME-1];
        bit_cnt_q  <= '0;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            joy_data_q <= 1'b1;
          end
          LOAD: begin
            state_q <= SHIFT;
            busy_q  <= 1'b1;
          end
          SHIFT: begin
            if (clk_rise) begin
              sr_q       <= {sr_q[FRAME-2:0], 1'b1};
              joy_data_q <= sr_q[FRAME-2];
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == CW'(FRAME - 1)) begin
                frame_done_q <= 1'b1;
                busy_q       <= 1'b0;
                state_q      <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (clk_rise) begin
              sr_q       <= {sr_q[FRAME-2:0], 1'b1};
              joy_data_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign joy_data   = joy_data_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule
